// File: rtl/sp2_pkg.sv
// Constants and types shared by the rectangle fill engine and the ST7789V3 SPI driver.
package sp2_pkg;

    localparam int H_RES     = 320;
    localparam int V_RES     = 172;
    localparam int PIX_COUNT = H_RES * V_RES;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        IDLE,
        CLIP,
        SYNC_WAIT,
        FILL,
        DONE
    } fill_state_t;

endpackage

// File: rtl/sp2_rect_fill.sv
// Solid RGB565 rectangle fill into the framebuffer: clips each command to the
// screen, optionally waits for end-of-frame, then writes one pixel per cycle.
module sp2_rect_fill #(
    parameter int H_RES     = sp2_pkg::H_RES,
    parameter int V_RES     = sp2_pkg::V_RES,
    parameter int PIX_COUNT = H_RES * V_RES,
    localparam int ADDR_W   = $clog2(PIX_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [15:0]       cmd_color,
    input  logic              cmd_sync,
    input  logic              frame_done,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [15:0]       fb_wdata,
    output logic              busy,
    output logic              done
);

    import sp2_pkg::*;

    localparam logic [10:0] H_RES_W = 11'(H_RES);
    localparam logic [10:0] V_RES_W = 11'(V_RES);

    fill_state_t state_reg, state_next;

    logic [8:0]        x_reg;
    logic [7:0]        y_reg;
    logic [9:0]        w_reg;
    logic [8:0]        h_reg;
    rgb565_t           color_reg;
    logic              sync_reg;
    logic              sync_seen_reg;
    logic [10:0]       x_end_reg, y_end_reg;
    logic [8:0]        col_reg;
    logic [7:0]        row_reg;
    logic [ADDR_W-1:0] row_base_reg;

    logic              cmd_ready_reg, busy_reg, done_reg, fb_we_reg;
    logic [ADDR_W-1:0] fb_waddr_reg;
    rgb565_t           fb_wdata_reg;

    logic        accept;
    logic [10:0] x_sum, y_sum, x_end_clip, y_end_clip;
    logic        clip_empty, col_last, row_last;

    assign accept = cmd_valid && cmd_ready_reg && (state_reg == IDLE);

    // Sums are 11 bits wide so 511+1023 cannot wrap before the clamp.
    always_comb begin
        x_sum      = {2'b00, x_reg} + {1'b0, w_reg};
        y_sum      = {3'b000, y_reg} + {2'b00, h_reg};
        x_end_clip = (x_sum > H_RES_W) ? H_RES_W : x_sum;
        y_end_clip = (y_sum > V_RES_W) ? V_RES_W : y_sum;
        clip_empty = (w_reg == '0) || (h_reg == '0) ||
                     ({2'b00, x_reg} >= H_RES_W) || ({3'b000, y_reg} >= V_RES_W);
        col_last   = ({2'b00, col_reg} == x_end_reg - 11'd1);
        row_last   = ({3'b000, row_reg} == y_end_reg - 11'd1);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (accept) state_next = CLIP;
            CLIP: begin
                if (clip_empty)    state_next = DONE;
                else if (sync_reg) state_next = SYNC_WAIT;
                else               state_next = FILL;
            end
            SYNC_WAIT: if (sync_seen_reg) state_next = FILL;
            FILL:      if (col_last && row_last) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            w_reg         <= '0;
            h_reg         <= '0;
            color_reg     <= '0;
            sync_reg      <= 1'b0;
            sync_seen_reg <= 1'b0;
            x_end_reg     <= '0;
            y_end_reg     <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            row_base_reg  <= '0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fb_we_reg     <= 1'b0;
            fb_waddr_reg  <= '0;
            fb_wdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            // Ready only re-arms after a full IDLE cycle, so it trails done by one.
            cmd_ready_reg <= (state_reg == IDLE) && (state_next == IDLE);
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_reg == DONE);
            fb_we_reg     <= (state_reg == FILL);

            if (accept) begin
                x_reg         <= cmd_x;
                y_reg         <= cmd_y;
                w_reg         <= cmd_w;
                h_reg         <= cmd_h;
                color_reg     <= cmd_color;
                sync_reg      <= cmd_sync;
                sync_seen_reg <= 1'b0;
            end else if (((state_reg == CLIP) || (state_reg == SYNC_WAIT)) && frame_done) begin
                sync_seen_reg <= 1'b1;
            end

            if (state_reg == CLIP) begin
                x_end_reg    <= x_end_clip;
                y_end_reg    <= y_end_clip;
                row_base_reg <= ADDR_W'(int'(y_reg) * H_RES);
                col_reg      <= x_reg;
                row_reg      <= y_reg;
            end

            // Row stepping adds H_RES to the base instead of multiplying per row.
            if (state_reg == FILL) begin
                fb_waddr_reg <= row_base_reg + ADDR_W'(col_reg);
                fb_wdata_reg <= color_reg;
                if (col_last) begin
                    col_reg      <= x_reg;
                    row_reg      <= row_reg + 8'd1;
                    row_base_reg <= row_base_reg + ADDR_W'(H_RES);
                end else begin
                    col_reg <= col_reg + 9'd1;
                end
            end
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign fb_we     = fb_we_reg;
    assign fb_waddr  = fb_waddr_reg;
    assign fb_wdata  = fb_wdata_reg;

endmodule

// File: tb/tb_sp2_rect_fill.sv
// Directed bench for sp2_rect_fill: expected pixel writes are queued when a
// command is issued and popped as the engine writes them.
module tb_sp2_rect_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [15:0] cmd_color;
    logic        cmd_sync;
    logic        frame_done;
    logic        fb_we;
    logic [15:0] fb_waddr;
    logic [15:0] fb_wdata;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    sp2_rect_fill dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
        .cmd_sync   (cmd_sync),
        .frame_done (frame_done),
        .fb_we      (fb_we),
        .fb_waddr   (fb_waddr),
        .fb_wdata   (fb_wdata),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [15:0] color, input bit sync, input int fd,
                           input int abort_after);
        int xe, ye, t_acc, first_cyc, last_cyc, done_cyc, nw, total, budget;
        logic [31:0] e;
        xe = (x + w > 320) ? 320 : x + w;
        ye = (y + h > 172) ? 172 : y + h;
        exp_q.delete();
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                exp_q.push_back({color, 16'(r * 320 + c)});
        total = exp_q.size();

        budget = 0;
        while (!cmd_ready && budget < 100) begin
            tick();
            budget++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 1);

        cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 10'(w); cmd_h = 9'(h);
        cmd_color = color; cmd_sync = sync; cmd_valid = 1'b1;
        tick();
        t_acc = cyc;
        cmd_valid = 1'b0;
        cmd_x = 9'($urandom); cmd_y = 8'($urandom); cmd_w = 10'($urandom);
        cmd_h = 9'($urandom); cmd_color = 16'($urandom); cmd_sync = ~sync;
        chk("ready_drop_on_accept", 32'(cmd_ready), 0);
        chk("busy_after_accept", 32'(busy), 1);

        first_cyc = -1; last_cyc = -1; done_cyc = -1; nw = 0;
        for (int k = 0; k < total + fd + 200; k++) begin
            frame_done = sync && (cyc == t_acc + fd - 1);
            tick();
            if (fb_we) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nw++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 32'(fb_we), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("waddr", 32'(fb_waddr), 32'(e[15:0]));
                    chk("wdata", 32'(fb_wdata), 32'(e[31:16]));
                end
                if (abort_after > 0 && nw == abort_after) begin
                    rst = 1'b1;
                    frame_done = 1'b0;
                    tick();
                    chk("we_after_rst", 32'(fb_we), 0);
                    chk("done_after_rst", 32'(done), 0);
                    chk("busy_after_rst", 32'(busy), 0);
                    rst = 1'b0;
                    tick();
                    chk("ready_after_rst_release", 32'(cmd_ready), 1);
                    chk("done_after_rst_release", 32'(done), 0);
                    exp_q.delete();
                    return;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        frame_done = 1'b0;

        chk("write_count", 32'(nw), 32'(total));
        if (total == 0) begin
            chk("empty_done_cyc", 32'(done_cyc), 32'(t_acc + 2));
        end else begin
            chk("first_we_cyc", 32'(first_cyc), 32'(t_acc + (sync ? fd + 2 : 2)));
            chk("done_cyc", 32'(done_cyc), 32'(last_cyc + 1));
        end
        tick();
        chk("done_one_cycle", 32'(done), 0);
        chk("ready_after_done", 32'(cmd_ready), 1);
        chk("busy_after_done", 32'(busy), 0);
        $display("cmd x=%0d y=%0d w=%0d h=%0d sync=%0d writes=%0d accept=%0d done=%0d",
                 x, y, w, h, sync, nw, t_acc, done_cyc);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = '0; cmd_sync = 1'b0; frame_done = 1'b0;
        tick(); tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_fb_we", 32'(fb_we), 0);
        chk("rst_fb_waddr", 32'(fb_waddr), 0);
        chk("rst_fb_wdata", 32'(fb_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        tick();
        chk("ready_first_cycle", 32'(cmd_ready), 1);

        run_cmd(0, 0, 320, 172, 16'hF800, 1'b0, 0, 0);
        run_cmd(10, 5, 3, 2, 16'h07E0, 1'b0, 0, 0);
        run_cmd(318, 170, 10, 10, 16'h001F, 1'b0, 0, 0);
        run_cmd(300, 0, 1023, 511, 16'hA5A5, 1'b0, 0, 0);
        run_cmd(20, 20, 0, 5, 16'h1111, 1'b0, 0, 0);
        run_cmd(320, 20, 5, 5, 16'h2222, 1'b0, 0, 0);
        run_cmd(20, 200, 5, 5, 16'h3333, 1'b0, 0, 0);

        // End-of-frame pulse while idle must not release the sync wait.
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        run_cmd(100, 50, 4, 3, 16'hFFE0, 1'b1, 50, 0);

        run_cmd(0, 0, 320, 10, 16'h7777, 1'b0, 0, 100);
        run_cmd(5, 160, 7, 20, 16'h1234, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sp2_rect_fill.md
# sp2_rect_fill

Rectangle fill engine that draws solid RGB565 rectangles into the 320x172 framebuffer RAM. The ST7789V3 SPI display driver later streams that RAM to the LCD. The engine takes one command at a time, clips it to the screen and writes one pixel per cycle on the framebuffer write port. It can optionally wait for the display driver's `frame_done` pulse before starting, to limit tearing.

## Interface
Parameters:
- `H_RES`, 320, display width in pixels
- `V_RES`, 172, display height in pixels
- `PIX_COUNT`, `H_RES*V_RES` (55040), framebuffer depth in pixels

Ports:
- `clk`  in  1  system clock (50 MHz)
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  engine idle; command accepted when `cmd_valid && cmd_ready`
- `cmd_x`  in  9  left column, 0..511
- `cmd_y`  in  8  top row, 0..255
- `cmd_w`  in  10  width in pixels, 0..1023
- `cmd_h`  in  9  height in pixels, 0..511
- `cmd_color`  in  16  RGB565 fill value
- `cmd_sync`  in  1  1 = wait for `frame_done` before writing
- `frame_done`  in  1  one-cycle end-of-frame pulse from the SPI driver
- `fb_we`  out  1  framebuffer write enable
- `fb_waddr`  out  16  pixel address, computed as `row*H_RES + col`
- `fb_wdata`  out  16  pixel data
- `busy`  out  1  a command is in progress
- `done`  out  1  one-cycle pulse when a command completes

One clock; reset is synchronous and active-high.

## Operation
States:
- **IDLE**
  - `cmd_ready`=1.
  - On accept, latch all `cmd_*` fields and go to CLIP.
- **CLIP** (1 cycle)
  - `x_end = min(cmd_x + cmd_w, H_RES)` and `y_end = min(cmd_y + cmd_h, V_RES)`, computed at 11 bits with no overflow.
  - The command is empty if `cmd_w==0`, `cmd_h==0`, `cmd_x>=H_RES` or `cmd_y>=V_RES`. Empty goes to DONE.
  - Load `row_base = cmd_y*H_RES` (constant multiply), `col = cmd_x`, `row = cmd_y`.
  - Next state: SYNC_WAIT if `cmd_sync`, otherwise FILL.
- **SYNC_WAIT**
  - Hold until `sync_seen` is set.
  - `sync_seen` is set by any `frame_done` pulse sampled in CLIP or SYNC_WAIT; it is cleared on accept.
  - Once set, go to FILL on the next cycle.
- **FILL**
  - Each cycle: `fb_we`=1, `fb_waddr = row_base + col`, `fb_wdata = color`.
  - `col` increments each write.
  - At `col == x_end-1`: `col` reloads to `cmd_x`, `row` increments, `row_base += H_RES` (no multiply in this loop).
  - At the last pixel (`row == y_end-1` and `col == x_end-1`): go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.

Rules:
- `busy`=1 in every state except IDLE.
- Fields are latched at accept; input changes after accept have no effect.
- `frame_done` pulses in IDLE are ignored.
- `fb_waddr` never reaches or exceeds `PIX_COUNT`.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=0, `fb_we`=0, `fb_waddr`=0, `fb_wdata`=0, `busy`=0, `done`=0.
- `cmd_ready` rises on the first cycle after `rst` deasserts.
- Relative to accept at edge T:
  - CLIP at T+1.
  - For a non-sync command, the first `fb_we` is visible at T+2.
  - Writes are back-to-back, one per cycle; total writes = `(x_end-cmd_x)*(y_end-cmd_y)`.
  - `done` is asserted the cycle after the last `fb_we`.
  - `cmd_ready` is asserted the cycle after `done`.
- Empty command: `done` at T+2 with no writes.
- With `cmd_sync`, if `frame_done` is sampled at cycle F (F ≥ T+1), the first write is at F+2.
- `rst` asserted mid-FILL: `fb_we`=0 from the next edge and the command is abandoned. No `done` is issued.

## Structure
- Shared package `sp2_pkg` holds:
  - `H_RES`, `V_RES`, `PIX_COUNT`
  - the RGB565 pixel typedef
  - the fill state enum (IDLE, CLIP, SYNC_WAIT, FILL, DONE)
- The SPI driver uses the same package constants.
- No sub-module. The dual-port framebuffer RAM is a separate, sibling block.

## Test plan
- Full screen, x=0 y=0 w=320 h=172, color 0xF800, no sync → 55040 consecutive writes, addresses 0..55039; `done` one cycle after address 55039.
- x=10 y=5 w=3 h=2, color 0x07E0 → addresses 1610, 1611, 1612, 1930, 1931, 1932 in order; first write at T+2.
- Clip: x=318 y=170 w=10 h=10 → 4 writes: 54718, 54719, 55038, 55039.
- Empty: w=0, or x=320, or y=200 → no `fb_we`; `done` at T+2.
- Sync: `cmd_sync`=1 with `frame_done` at T+50 → no writes before T+52; first write at T+52. A `frame_done` pulse while IDLE before accept is ignored.
- Reset mid-fill: assert `rst` after 100 writes → `fb_we`=0 next cycle; after release `cmd_ready`=1 and a new command fills correctly.
